// File: rtl/btb_assoc.sv
// btb_assoc: N-way set-associative branch target buffer with a registered lookup,
// round-robin replacement and a set-by-set flush engine.
module btb_assoc #(
    parameter int PC_W     = 64,
    parameter int IDX_W    = 8,
    parameter int NWAYS    = 4,
    parameter int CNT_W    = 2,
    parameter int CNT_INIT = 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     lkp_vld_i,
    input  logic [PC_W-1:0]          lkp_pc_i,
    input  logic                     alc_we_i,
    input  logic [PC_W-1:0]          alc_pc_i,
    input  logic [2:0]               alc_pos_i,
    input  logic [1:0]               alc_typ_i,
    input  logic [PC_W-1:0]          alc_tar_i,
    input  logic [1:0]               alc_ras_i,
    input  logic                     upd_we_i,
    input  logic [PC_W-1:0]          upd_pc_i,
    input  logic                     upd_dir_i,
    input  logic [PC_W-1:0]          upd_tar_i,
    input  logic                     flush_i,
    output logic                     busy_o,
    output logic                     hit_o,
    output logic [$clog2(NWAYS)-1:0] way_o,
    output logic [2:0]               br_pos_o,
    output logic [1:0]               br_typ_o,
    output logic [PC_W-1:0]          br_tar_o,
    output logic                     br_dir_o,
    output logic [1:0]               ras_ctl_o
);
    localparam int NSETS = 1 << IDX_W;
    localparam int WAY_W = $clog2(NWAYS);
    localparam int TAG_W = PC_W - IDX_W - 2;
    localparam logic [1:0] BR_COND = 2'd0, BR_INDIR_RAS = 2'd1, BR_INDIR_PC = 2'd2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ALC = CNT_W'(CNT_INIT);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t                 state_q;
    logic [IDX_W-1:0]       fcnt_q;
    logic [NWAYS-1:0]       vld_q [NSETS];
    logic [WAY_W-1:0]       rr_q  [NSETS];
    logic [TAG_W-1:0]       tag_q [NSETS][NWAYS];
    logic [2:0]             pos_q [NSETS][NWAYS];
    logic [1:0]             typ_q [NSETS][NWAYS];
    logic [PC_W-1:0]        tar_q [NSETS][NWAYS];
    logic [CNT_W-1:0]       cnt_q [NSETS][NWAYS];
    logic [1:0]             ras_q [NSETS][NWAYS];

    logic                   hit_q, dir_q;
    logic [WAY_W-1:0]       way_q;
    logic [2:0]             pos_o_q;
    logic [1:0]             typ_o_q, ras_o_q;
    logic [PC_W-1:0]        tar_o_q;

    logic [IDX_W-1:0]       l_idx, a_idx, u_idx;
    logic [TAG_W-1:0]       l_tag, a_tag, u_tag;
    logic [NWAYS-1:0]       l_m, a_m, u_m, a_inv;
    logic [WAY_W-1:0]       l_way, a_way, u_way;
    logic [CNT_W-1:0]       u_cnt, u_cnt_n, a_cnt;
    logic [1:0]             u_typ;
    logic                   act, alc_en, upd_en, upd_wr, u_ind, lv, byp_a, byp_u, hit_d, dir_d;
    logic [2:0]             pos_d;
    logic [1:0]             typ_d, ras_d;
    logic [PC_W-1:0]        tar_d;

    function automatic logic [WAY_W-1:0] enc(input logic [NWAYS-1:0] m);
        enc = '0;
        for (int w = NWAYS - 1; w >= 0; w--)
            if (m[w]) enc = WAY_W'(w);
    endfunction

    assign l_idx = lkp_pc_i[IDX_W+1:2];
    assign a_idx = alc_pc_i[IDX_W+1:2];
    assign u_idx = upd_pc_i[IDX_W+1:2];
    assign l_tag = lkp_pc_i[PC_W-1:IDX_W+2];
    assign a_tag = alc_pc_i[PC_W-1:IDX_W+2];
    assign u_tag = upd_pc_i[PC_W-1:IDX_W+2];

    always_comb begin
        l_m = '0;
        a_m = '0;
        u_m = '0;
        for (int w = 0; w < NWAYS; w++) begin
            l_m[w] = vld_q[l_idx][w] && tag_q[l_idx][w] == l_tag;
            a_m[w] = vld_q[a_idx][w] && tag_q[a_idx][w] == a_tag;
            u_m[w] = vld_q[u_idx][w] && tag_q[u_idx][w] == u_tag;
        end
    end

    // Flush (pending or running) blocks every table write in the same cycle.
    assign act     = state_q == IDLE && !flush_i;
    assign alc_en  = act && alc_we_i && !(|a_m);
    assign upd_en  = act && upd_we_i && |u_m;
    assign a_inv   = ~vld_q[a_idx];
    assign a_way   = |a_inv ? enc(a_inv) : rr_q[a_idx];
    assign a_cnt   = alc_typ_i == BR_COND ? CNT_ALC : CNT_MAX;
    assign u_way   = enc(u_m);
    assign u_cnt   = cnt_q[u_idx][u_way];
    assign u_typ   = typ_q[u_idx][u_way];
    assign u_ind   = u_typ == BR_INDIR_RAS || u_typ == BR_INDIR_PC;
    assign u_cnt_n = upd_dir_i ? (u_cnt == CNT_MAX ? u_cnt : u_cnt + CNT_W'(1))
                   : (u_typ == BR_COND && u_cnt != '0) ? u_cnt - CNT_W'(1) : u_cnt;
    assign upd_wr  = upd_en && !(alc_en && a_idx == u_idx && a_way == u_way);

    assign lv    = lkp_vld_i && state_q == IDLE;
    assign l_way = enc(l_m);
    assign byp_a = alc_en && alc_pc_i == lkp_pc_i;
    assign byp_u = upd_wr && upd_pc_i == lkp_pc_i;
    assign hit_d = lv && (byp_a || |l_m);
    assign pos_d = byp_a ? alc_pos_i : pos_q[l_idx][l_way];
    assign typ_d = byp_a ? alc_typ_i : typ_q[l_idx][l_way];
    assign ras_d = byp_a ? alc_ras_i : ras_q[l_idx][l_way];
    assign dir_d = byp_a ? a_cnt[CNT_W-1] : byp_u ? u_cnt_n[CNT_W-1] : cnt_q[l_idx][l_way][CNT_W-1];
    assign tar_d = byp_a ? alc_tar_i : (byp_u && u_ind) ? upd_tar_i : tar_q[l_idx][l_way];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            fcnt_q  <= '0;
            for (int s = 0; s < NSETS; s++) begin
                vld_q[s] <= '0;
                rr_q[s]  <= '0;
            end
            hit_q   <= 1'b0;
            way_q   <= '0;
            pos_o_q <= '0;
            typ_o_q <= '0;
            tar_o_q <= '0;
            dir_q   <= 1'b0;
            ras_o_q <= '0;
        end else begin
            if (state_q == FLUSH) begin
                vld_q[fcnt_q] <= '0;
                rr_q[fcnt_q]  <= '0;
            end
            if (alc_en) begin
                vld_q[a_idx][a_way] <= 1'b1;
                if (!(|a_inv)) rr_q[a_idx] <= rr_q[a_idx] + WAY_W'(1);
            end
            if (flush_i) begin
                state_q <= FLUSH;
                fcnt_q  <= '0;
            end else if (state_q == FLUSH) begin
                fcnt_q <= fcnt_q + IDX_W'(1);
                if (fcnt_q == '1) state_q <= IDLE;
            end
            hit_q   <= hit_d;
            way_q   <= hit_d ? (byp_a ? a_way : l_way) : '0;
            pos_o_q <= hit_d ? pos_d : '0;
            typ_o_q <= hit_d ? typ_d : '0;
            tar_o_q <= hit_d ? tar_d : '0;
            dir_q   <= hit_d && dir_d;
            ras_o_q <= hit_d ? ras_d : '0;
        end
    end

    // Allocate is written after update so it wins when both target one entry.
    always_ff @(posedge clock) begin
        if (upd_wr) begin
            cnt_q[u_idx][u_way] <= u_cnt_n;
            if (u_ind) tar_q[u_idx][u_way] <= upd_tar_i;
        end
        if (alc_en) begin
            tag_q[a_idx][a_way] <= a_tag;
            pos_q[a_idx][a_way] <= alc_pos_i;
            typ_q[a_idx][a_way] <= alc_typ_i;
            tar_q[a_idx][a_way] <= alc_tar_i;
            cnt_q[a_idx][a_way] <= a_cnt;
            ras_q[a_idx][a_way] <= alc_ras_i;
        end
    end

    assign busy_o    = state_q == FLUSH;
    assign hit_o     = hit_q;
    assign way_o     = way_q;
    assign br_pos_o  = pos_o_q;
    assign br_typ_o  = typ_o_q;
    assign br_tar_o  = tar_o_q;
    assign br_dir_o  = dir_q;
    assign ras_ctl_o = ras_o_q;
endmodule

// File: tb/tb_btb_assoc.sv
// tb_btb_assoc: directed self-checking bench for btb_assoc with default parameters.
module tb_btb_assoc;
    localparam logic [1:0] COND = 2'd0, IRAS = 2'd1, IPC = 2'd2, OTH = 2'd3;

    logic        clock = 1'b0, reset_n = 1'b0;
    logic        lkp_vld = 0, alc_we = 0, upd_we = 0, upd_dir = 0, flush = 0;
    logic [63:0] lkp_pc = 0, alc_pc = 0, alc_tar = 0, upd_pc = 0, upd_tar = 0;
    logic [2:0]  alc_pos = 0;
    logic [1:0]  alc_typ = 0, alc_ras = 0;
    logic        busy_o, hit_o, br_dir_o;
    logic [1:0]  way_o, br_typ_o, ras_ctl_o;
    logic [2:0]  br_pos_o;
    logic [63:0] br_tar_o;
    int          checks = 0, failures = 0, n;

    btb_assoc dut (
        .clock(clock), .reset_n(reset_n),
        .lkp_vld_i(lkp_vld), .lkp_pc_i(lkp_pc),
        .alc_we_i(alc_we), .alc_pc_i(alc_pc), .alc_pos_i(alc_pos), .alc_typ_i(alc_typ),
        .alc_tar_i(alc_tar), .alc_ras_i(alc_ras),
        .upd_we_i(upd_we), .upd_pc_i(upd_pc), .upd_dir_i(upd_dir), .upd_tar_i(upd_tar),
        .flush_i(flush), .busy_o(busy_o), .hit_o(hit_o), .way_o(way_o),
        .br_pos_o(br_pos_o), .br_typ_o(br_typ_o), .br_tar_o(br_tar_o),
        .br_dir_o(br_dir_o), .ras_ctl_o(ras_ctl_o)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
        lkp_vld = 0; alc_we = 0; upd_we = 0; flush = 0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic h, input logic [1:0] w, input logic [2:0] p,
                           input logic [1:0] t, input logic [63:0] tar, input logic d, input logic [1:0] r);
        chk({tag, ".hit"}, 64'(hit_o), 64'(h));
        chk({tag, ".way"}, 64'(way_o), 64'(w));
        chk({tag, ".pos"}, 64'(br_pos_o), 64'(p));
        chk({tag, ".typ"}, 64'(br_typ_o), 64'(t));
        chk({tag, ".tar"}, br_tar_o, tar);
        chk({tag, ".dir"}, 64'(br_dir_o), 64'(d));
        chk({tag, ".ras"}, 64'(ras_ctl_o), 64'(r));
    endtask

    task automatic lk(input logic [63:0] pc);
        lkp_vld = 1; lkp_pc = pc;
    endtask

    task automatic al(input logic [63:0] pc, input logic [2:0] p, input logic [1:0] t,
                      input logic [63:0] tar, input logic [1:0] r);
        alc_we = 1; alc_pc = pc; alc_pos = p; alc_typ = t; alc_tar = tar; alc_ras = r;
    endtask

    task automatic up(input logic [63:0] pc, input logic d, input logic [63:0] tar);
        upd_we = 1; upd_pc = pc; upd_dir = d; upd_tar = tar;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1 reset_n = 1;
        chk("reset.busy", 64'(busy_o), 0);
        chk_out("reset", 0, 0, 0, 0, 0, 0, 0);
        lk(64'h1000); tick;
        chk_out("miss_after_reset", 0, 0, 0, 0, 0, 0, 0);
        chk("miss_after_reset.busy", 64'(busy_o), 0);

        // Counter behaviour on a conditional branch (CNT_INIT=1)
        al(64'h1000, 3, COND, 64'h2000, 2); lk(64'h1000); tick;
        chk_out("alc_bypass", 1, 0, 3, COND, 64'h2000, 0, 2);
        up(64'h1000, 1, 64'hdead); lk(64'h1000); tick;
        chk("upd_t1.dir", 64'(br_dir_o), 1);
        chk("cond_tar_kept", br_tar_o, 64'h2000);
        repeat (4) begin up(64'h1000, 1, 0); tick; end
        up(64'h1000, 0, 0); lk(64'h1000); tick;
        chk("sat_hi_then_nt.dir", 64'(br_dir_o), 1);
        up(64'h1000, 0, 0); lk(64'h1000); tick;
        chk("nt_to_1.dir", 64'(br_dir_o), 0);
        up(64'h1000, 0, 0); tick;
        up(64'h1000, 0, 0); lk(64'h1000); tick;
        chk("sat_lo.dir", 64'(br_dir_o), 0);
        up(64'h1000, 1, 0); tick;
        up(64'h1000, 1, 0); lk(64'h1000); tick;
        chk("inc_from_lo.dir", 64'(br_dir_o), 1);
        lk(64'h1000); tick;
        chk_out("stored", 1, 0, 3, COND, 64'h2000, 1, 2);

        // Fill set 0, then round-robin replacement
        for (int i = 1; i < 4; i++) begin
            al(64'h1000 + 64'(i) * 64'h400, 1, OTH, 64'h1010 + 64'(i) * 64'h400, 0);
            lk(64'h1000 + 64'(i) * 64'h400); tick;
            chk("fill.way", 64'(way_o), 64'(i));
        end
        al(64'h2000, 1, OTH, 64'h2010, 0); lk(64'h2000); tick;
        chk("fill_rr.way", 64'(way_o), 0);
        lk(64'h1000); tick;
        chk("evicted.hit", 64'(hit_o), 0);
        lk(64'h1400); tick;
        chk_out("kept", 1, 1, 1, OTH, 64'h1410, 1, 0);
        al(64'h1400, 6, COND, 64'h9999, 3); lk(64'h1400); tick;
        chk_out("realloc_nowrite", 1, 1, 1, OTH, 64'h1410, 1, 0);
        al(64'h2400, 2, OTH, 64'h2410, 0); lk(64'h2400); tick;
        chk("rr_unchanged.way", 64'(way_o), 1);
        lk(64'h1400); tick;
        chk("victim_gone.hit", 64'(hit_o), 0);

        // Unconditional entry ignores not-taken updates
        al(64'h5004, 2, OTH, 64'h5100, 0); tick;
        up(64'h5004, 0, 0); tick;
        up(64'h5004, 0, 0); lk(64'h5004); tick;
        chk("uncond_nt.dir", 64'(br_dir_o), 1);
        lk(64'h5004); tick;
        chk_out("uncond_stored", 1, 0, 2, OTH, 64'h5100, 1, 0);

        // Indirect target update with same-cycle lookup
        al(64'h6008, 4, IPC, 64'h100, 1); tick;
        up(64'h6008, 1, 64'h3000); lk(64'h6008); tick;
        chk_out("indir_byp", 1, 0, 4, IPC, 64'h3000, 1, 1);
        lk(64'h6008); tick;
        chk("indir_stored.tar", br_tar_o, 64'h3000);
        al(64'h900C, 5, IRAS, 64'h9100, 3); up(64'h6008, 1, 64'h4000); tick;
        lk(64'h900C); tick;
        chk_out("dual_alc", 1, 0, 5, IRAS, 64'h9100, 1, 3);
        lk(64'h6008); tick;
        chk("dual_upd.tar", br_tar_o, 64'h4000);

        // Flush
        flush = 1; tick;
        chk("flush_start.busy", 64'(busy_o), 1);
        lk(64'h2000); al(64'h7000, 0, COND, 64'h7100, 0); tick;
        n = 1;
        chk("flush_lkp.hit", 64'(hit_o), 0);
        while (busy_o && n < 400) begin tick; n++; end
        chk("flush_len", 64'(n), 256);
        lk(64'h2000); tick;
        chk("post_flush.hit", 64'(hit_o), 0);
        lk(64'h7000); tick;
        chk("mid_flush_alc_ignored.hit", 64'(hit_o), 0);
        al(64'h7000, 0, COND, 64'h7100, 0); lk(64'h7000); tick;
        chk_out("alc_after_flush", 1, 0, 0, COND, 64'h7100, 0, 0);

        flush = 1; tick;
        n = 0;
        while (n < 100) begin tick; n++; end
        chk("pre_restart.busy", 64'(busy_o), 1);
        flush = 1; tick;
        n = 0;
        while (busy_o && n < 400) begin tick; n++; end
        chk("restart_len", 64'(n), 256);

        flush = 1; tick;
        repeat (5) tick;
        reset_n = 0;
        #1;
        chk("async_rst.busy", 64'(busy_o), 0);
        chk("async_rst.hit", 64'(hit_o), 0);
        #2 reset_n = 1;
        lk(64'h7000); tick;
        chk("after_rst.hit", 64'(hit_o), 0);
        chk("after_rst.busy", 64'(busy_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
